// File: rtl/cam_pkg.sv
// Shared types and helpers for the CAPP storage/search array.
// Holds default geometry and the write-line pair indexing.
package cam_pkg;

    localparam int unsigned DefNumBits  = 2;
    localparam int unsigned DefNumCells = 10;

    typedef enum logic [1:0] {
        TagHold,
        TagSet,
        TagSearch,
        TagSelect
    } tag_op_e;

    function automatic int unsigned set_one_idx(input int unsigned i);
        return 2 * i;
    endfunction

    function automatic int unsigned set_zero_idx(input int unsigned i);
        return 2 * i + 1;
    endfunction

endpackage

// File: rtl/cam_cell.sv
// One CAPP word: storage, tag flip-flop, masked match,
// write-pair decode and tag-gated read output.
module cam_cell
    import cam_pkg::*;
#(
    parameter int unsigned NB = DefNumBits
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [NB-1:0] comparand_i,
    input  logic [NB-1:0] mask_i,
    input  logic [2*NB-1:0] wl_i,
    input  tag_op_e       op_i,
    input  logic          seen_i,
    output logic          tag_o,
    output logic [NB-1:0] rd_o
);

    logic [NB-1:0] word_q, word_d;
    logic          tag_q, tag_d;
    logic [NB-1:0] one_ln, zero_ln;
    logic          match;

    for (genvar i = 0; i < NB; i++) begin : g_wl
        assign one_ln[i]  = wl_i[set_one_idx(i)];
        assign zero_ln[i] = wl_i[set_zero_idx(i)];
    end

    assign match = &(~mask_i | ~(word_q ^ comparand_i));

    // Conflicting or idle pairs leave the bit alone.
    always_comb begin
        word_d = word_q;
        if (tag_q) begin
            word_d = (word_q | (one_ln & ~zero_ln))
                   & ~(zero_ln & ~one_ln);
        end
    end

    always_comb begin
        tag_d = tag_q;
        unique case (op_i)
            TagSet:    tag_d = 1'b1;
            TagSearch: tag_d = tag_q & match;
            TagSelect: tag_d = tag_q & ~seen_i;
            default:   tag_d = tag_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            tag_q  <= 1'b0;
        end else begin
            word_q <= word_d;
            tag_q  <= tag_d;
        end
    end

    assign tag_o = tag_q;
    assign rd_o  = tag_q ? word_q : '0;

endmodule

// File: rtl/cam.sv
// CAPP array top: cell bank, first-responder chain
// and wired-OR read reduction.
module cam
    import cam_pkg::*;
#(
    parameter int unsigned num_bits  = DefNumBits,
    parameter int unsigned num_cells = DefNumCells
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [num_bits-1:0]   comparand,
    input  logic [num_bits-1:0]   mask,
    input  logic                  perform_search,
    input  logic                  set,
    input  logic                  select_first,
    input  logic [2*num_bits-1:0] write_lines,
    output logic [num_cells-1:0]  tag_wires,
    output logic [num_bits-1:0]   read_lines
);

    tag_op_e             op;
    logic [num_cells:0]  seen;
    logic [num_bits-1:0] rd [num_cells];

    always_comb begin
        op = TagHold;
        priority case (1'b1)
            set:            op = TagSet;
            perform_search: op = TagSearch;
            select_first:   op = TagSelect;
            default:        op = TagHold;
        endcase
    end

    // seen[k] is high when any lower-index tag is set.
    assign seen[0] = 1'b0;

    for (genvar k = 0; k < num_cells; k++) begin : g_cell
        cam_cell #(
            .NB(num_bits)
        ) u_cell (
            .clk_i      (CLK),
            .rst_ni     (RST_N),
            .comparand_i(comparand),
            .mask_i     (mask),
            .wl_i       (write_lines),
            .op_i       (op),
            .seen_i     (seen[k]),
            .tag_o      (tag_wires[k]),
            .rd_o       (rd[k])
        );
        assign seen[k+1] = seen[k] | tag_wires[k];
    end

    always_comb begin
        read_lines = '0;
        for (int k = 0; k < num_cells; k++) begin
            read_lines = read_lines | rd[k];
        end
    end

endmodule

// File: tb/tb_cam.sv
// Directed plus random bench for the CAPP array,
// compared against an array-based behavioural model.
module tb_cam;
    localparam int NB = 2;
    localparam int NC = 10;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [NB-1:0] comparand = '0;
    logic [NB-1:0] mask = '0;
    logic          perform_search = 1'b0;
    logic          set = 1'b0;
    logic          select_first = 1'b0;
    logic [2*NB-1:0] write_lines = '0;
    logic [NC-1:0] tag_wires;
    logic [NB-1:0] read_lines;

    int total = 0;
    int bad = 0;

    logic [NB-1:0] mw [NC];
    bit            mt [NC];

    cam #(.num_bits(NB), .num_cells(NC)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .comparand     (comparand),
        .mask          (mask),
        .perform_search(perform_search),
        .set           (set),
        .select_first  (select_first),
        .write_lines   (write_lines),
        .tag_wires     (tag_wires),
        .read_lines    (read_lines)
    );

    always #5 CLK = ~CLK;

    function automatic logic [NC-1:0] m_tags();
        logic [NC-1:0] r = '0;
        for (int k = 0; k < NC; k++) r[k] = mt[k];
        return r;
    endfunction

    function automatic logic [NB-1:0] m_read();
        logic [NB-1:0] r = '0;
        for (int k = 0; k < NC; k++) if (mt[k]) r = r | mw[k];
        return r;
    endfunction

    function automatic logic [2*NB-1:0] wv(input logic [NB-1:0] v);
        logic [2*NB-1:0] r = '0;
        for (int i = 0; i < NB; i++) begin
            if (v[i]) r[2*i] = 1'b1;
            else r[2*i+1] = 1'b1;
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            mw[k] = '0;
            mt[k] = 0;
        end
    endtask

    task automatic model_clock();
        bit old_t [NC];
        bit found;
        for (int k = 0; k < NC; k++) old_t[k] = mt[k];
        if (set) begin
            for (int k = 0; k < NC; k++) mt[k] = 1;
        end else if (perform_search) begin
            for (int k = 0; k < NC; k++)
                mt[k] = old_t[k] && ((mw[k] & mask) == (comparand & mask));
        end else if (select_first) begin
            found = 0;
            for (int k = 0; k < NC; k++) begin
                mt[k] = old_t[k] && !found;
                if (old_t[k]) found = 1;
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (old_t[k]) begin
                for (int i = 0; i < NB; i++) begin
                    if (write_lines[2*i] && !write_lines[2*i+1])
                        mw[k][i] = 1'b1;
                    else if (!write_lines[2*i] && write_lines[2*i+1])
                        mw[k][i] = 1'b0;
                end
            end
        end
    endtask

    task automatic cyc(input bit s, input bit ps, input bit sf,
                       input logic [NB-1:0] c, input logic [NB-1:0] m,
                       input logic [2*NB-1:0] wl);
        set = s;
        perform_search = ps;
        select_first = sf;
        comparand = c;
        mask = m;
        write_lines = wl;
        @(posedge CLK);
        model_clock();
        #1;
        set = 0;
        perform_search = 0;
        select_first = 0;
        write_lines = '0;
        chk("model_tags", tag_wires, m_tags());
        chk("model_read", read_lines, m_read());
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        model_reset();
        #1;
        chk("rst_tags", tag_wires, 10'h000);
        chk("rst_read", read_lines, 2'b00);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic srch(input logic [NB-1:0] c, input logic [NB-1:0] m);
        cyc(0, 1, 0, c, m, '0);
    endtask

    task automatic setc();
        cyc(1, 0, 0, '0, '0, '0);
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        cyc(0, 0, 0, '0, '0, 4'b0101);
        cyc(0, 0, 0, '0, '0, 4'b0101);
        chk("nowrite_tags", tag_wires, 10'h000);
        setc();
        chk("nowrite_read", read_lines, 2'b00);

        cyc(0, 0, 0, '0, '0, 4'b1010);
        srch(2'b00, 2'b11);
        chk("clear_tags", tag_wires, 10'h3FF);
        chk("clear_read", read_lines, 2'b00);

        cyc(0, 0, 1, '0, '0, '0);
        chk("sel_first", tag_wires, 10'h001);
        cyc(0, 0, 0, '0, '0, 4'b0110);
        chk("write_read", read_lines, 2'b10);
        setc();
        srch(2'b10, 2'b11);
        chk("search_10", tag_wires, 10'h001);
        setc();
        srch(2'b00, 2'b11);
        chk("search_00", tag_wires, 10'h3FE);

        setc();
        srch(2'b11, 2'b10);
        chk("mask_10", tag_wires, 10'h001);
        setc();
        srch(2'b11, 2'b00);
        chk("mask_00", tag_wires, 10'h3FF);

        cyc(1, 1, 0, 2'b11, 2'b11, '0);
        chk("prio_set", tag_wires, 10'h3FF);
        srch(2'b11, 2'b11);
        chk("nomatch", tag_wires, 10'h000);
        cyc(0, 0, 1, '0, '0, '0);
        chk("sel_empty", tag_wires, 10'h000);
        chk("sel_empty_rd", read_lines, 2'b00);

        do_reset();
        for (int n = 1; n <= 3; n++) begin
            setc();
            srch(2'b00, 2'b11);
            cyc(0, 0, 1, '0, '0, '0);
            cyc(0, 0, 0, '0, '0, wv(n[NB-1:0]));
        end
        for (int n = 1; n <= 3; n++) begin
            setc();
            srch(n[NB-1:0], 2'b11);
            chk("fill_cell", tag_wires, 10'h001 << (n - 1));
        end
        chk("fill_read", read_lines, 2'b11);

        for (int t = 0; t < 400; t++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) == 0, NB'($urandom), NB'($urandom),
                (2*NB)'($urandom));
            if (t == 200) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
